axis_num_gen: RTL and testbench

- Traffic-generator endpoint for the AXI-Stream mesh NoC.
- On a START request it emits one fixed-length packet of pseudo-random words, produced by an LFSR, toward a configured destination node.
- Its slave side sinks and tallies packets delivered by the mesh.
- One instance attaches to each active mesh port.

---
 rtl/axis_num_gen.sv | 132 +++++++++++++
 tb/tb_axis_num_gen.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_num_gen.sv
// AXI-Stream traffic generator endpoint: emits LFSR-filled packets on START and tallies sunk beats.
// Build option: define NUM_GEN_RX_STATS_EN to build the RX_BEATS/RX_PKTS/RX_SUM counters.
module axis_num_gen #(
    parameter int                 TDATAW       = 32,
    parameter int                 TDESTW       = 4,
    parameter int                 TIDW         = 2,
    parameter int                 LFSR_DW      = 8,
    parameter logic [LFSR_DW-1:0] LFSR_DEFAULT = 8'h01,
    parameter int                 BURST_LEN    = 4,
    parameter int                 DEST_ID      = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              AXIS_S_TVALID,
    output logic              AXIS_S_TREADY,
    input  logic [TDATAW-1:0] AXIS_S_TDATA,
    input  logic              AXIS_S_TLAST,
    input  logic [TDESTW-1:0] AXIS_S_TDEST,
    output logic              AXIS_M_TVALID,
    input  logic              AXIS_M_TREADY,
    output logic [TDATAW-1:0] AXIS_M_TDATA,
    output logic              AXIS_M_TLAST,
    output logic [TDESTW-1:0] AXIS_M_TDEST,
    output logic              BUSY,
    output logic [15:0]       RX_BEATS,
    output logic [15:0]       RX_PKTS,
    output logic [TDATAW-1:0] RX_SUM
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    // An all-zero seed would lock the LFSR, so it is promoted to 1.
    localparam logic [LFSR_DW-1:0] SEED     = (LFSR_DEFAULT == '0) ? LFSR_DW'(1) : LFSR_DEFAULT;
    localparam logic [7:0]         LAST_IDX = 8'(BURST_LEN - 1);

    logic [0:0]         r_state;
    logic [7:0]         r_beat_cnt;
    logic [LFSR_DW-1:0] r_lfsr;
    logic               r_s_tready;

    logic               w_m_fire;
    logic               w_is_last;
    logic [LFSR_DW-1:0] w_lfsr_next;
    logic [TIDW-1:0]    w_unused_tid;

    assign w_is_last   = (r_beat_cnt == LAST_IDX);
    assign w_m_fire    = AXIS_M_TVALID & AXIS_M_TREADY;
    assign w_lfsr_next = {r_lfsr[LFSR_DW-2:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    assign w_unused_tid = '0;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_beat_cnt <= '0;
            r_lfsr     <= SEED;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (START) begin
                        r_state    <= ST_SEND;
                        r_beat_cnt <= '0;
                    end
                end
                default: begin
                    if (w_m_fire) begin
                        r_beat_cnt <= r_beat_cnt + 8'd1;
                        r_lfsr     <= w_lfsr_next;
                        if (w_is_last) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    // Master outputs derive only from registered state, so they hold steady through a stall.
    assign AXIS_M_TVALID = (r_state == ST_SEND);
    assign AXIS_M_TLAST  = AXIS_M_TVALID & w_is_last;
    assign AXIS_M_TDATA  = TDATAW'(r_lfsr);
    assign AXIS_M_TDEST  = TDESTW'(DEST_ID);
    assign BUSY          = AXIS_M_TVALID;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_s_tready <= 1'b0;
        end else begin
            r_s_tready <= 1'b1;
        end
    end

    assign AXIS_S_TREADY = r_s_tready;

`ifdef NUM_GEN_RX_STATS_EN
    logic [15:0]       r_rx_beats;
    logic [15:0]       r_rx_pkts;
    logic [TDATAW-1:0] r_rx_sum;
    logic [TDESTW-1:0] w_unused_dest;

    assign w_unused_dest = AXIS_S_TDEST;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rx_beats <= '0;
            r_rx_pkts  <= '0;
            r_rx_sum   <= '0;
        end else if (AXIS_S_TVALID && r_s_tready) begin
            r_rx_beats <= r_rx_beats + 16'd1;
            r_rx_sum   <= r_rx_sum + AXIS_S_TDATA;
            if (AXIS_S_TLAST) begin
                r_rx_pkts <= r_rx_pkts + 16'd1;
            end
        end
    end

    assign RX_BEATS = r_rx_beats;
    assign RX_PKTS  = r_rx_pkts;
    assign RX_SUM   = r_rx_sum;
`else
    logic w_unused_slave;

    assign w_unused_slave = ^{AXIS_S_TVALID, AXIS_S_TDATA, AXIS_S_TLAST, AXIS_S_TDEST};

    assign RX_BEATS = '0;
    assign RX_PKTS  = '0;
    assign RX_SUM   = '0;
`endif

endmodule

// File: tb/tb_axis_num_gen.sv
// Self-checking bench for axis_num_gen: three instances with seeds 0x01, 0x10 and 0x00.
module tb_axis_num_gen;

    localparam int BURST = 4;
`ifdef NUM_GEN_RX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct {
        logic        tvalid;
        logic [31:0] tdata;
        logic        tlast;
        logic [15:0] exp_beats;
        logic [15:0] exp_pkts;
        logic [31:0] exp_sum;
    } rx_vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  start;
    logic [2:0]  m_tready;
    logic [2:0]  m_tvalid;
    logic [2:0]  m_tlast;
    logic [2:0]  busy;
    logic [2:0]  s_tready;
    logic [31:0] m_tdata  [3];
    logic [3:0]  m_tdest  [3];
    logic [15:0] rx_beats [3];
    logic [15:0] rx_pkts  [3];
    logic [31:0] rx_sum   [3];
    logic        s_tvalid;
    logic [31:0] s_tdata;
    logic        s_tlast;
    logic [3:0]  s_tdest;

    logic [7:0]  model [3];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        axis_num_gen #(
            .LFSR_DEFAULT((g == 0) ? 8'h01 : (g == 1) ? 8'h10 : 8'h00)
        ) u_dut (
            .CLK          (clk),
            .RST          (rst),
            .START        (start[g]),
            .AXIS_S_TVALID(s_tvalid),
            .AXIS_S_TREADY(s_tready[g]),
            .AXIS_S_TDATA (s_tdata),
            .AXIS_S_TLAST (s_tlast),
            .AXIS_S_TDEST (s_tdest),
            .AXIS_M_TVALID(m_tvalid[g]),
            .AXIS_M_TREADY(m_tready[g]),
            .AXIS_M_TDATA (m_tdata[g]),
            .AXIS_M_TLAST (m_tlast[g]),
            .AXIS_M_TDEST (m_tdest[g]),
            .BUSY         (busy[g]),
            .RX_BEATS     (rx_beats[g]),
            .RX_PKTS      (rx_pkts[g]),
            .RX_SUM       (rx_sum[g])
        );
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Spec rule: shift left, feedback = parity of bits 7,5,4,3.
    function automatic logic [7:0] lfsr_step(input logic [7:0] x);
        int v  = int'(x);
        int fb = ((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1;
        return 8'(((v << 1) | fb) & 255);
    endfunction

    task automatic reset_model();
        model[0] = 8'h01;
        model[1] = 8'h10;
        model[2] = 8'h01;
    endtask

    function automatic logic ready_for(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (cyc % 2) == 0;
        return $urandom_range(0, 3) != 0;
    endfunction

    // Entered just after a rising edge; returns at the falling edge after the packet ends.
    task automatic run_pkt(input int d, input int mode, input int start_cycles, input bit hold_start);
        logic [7:0]  exp_data [BURST];
        logic [31:0] prev_data = '0;
        logic        prev_last = 1'b0;
        bit          prev_stall = 1'b0;
        int          beats = 0;
        int          busy_cycles = 0;
        int          cyc = 1;
        for (int i = 0; i < BURST; i++) begin
            exp_data[i] = model[d];
            model[d]    = lfsr_step(model[d]);
        end
        start[d] = 1'b1;
        m_tready[d] = ready_for(mode, 0);
        @(negedge clk);
        check("valid_before_start_sampled", m_tvalid[d], 1'b0);
        @(posedge clk); #1;
        while (beats < BURST && cyc < 64) begin
            start[d]    = (cyc < start_cycles) || hold_start;
            m_tready[d] = ready_for(mode, cyc);
            @(negedge clk);
            if (cyc == 1) check("first_valid_latency", m_tvalid[d], 1'b1);
            if (busy[d]) busy_cycles++;
            if (m_tvalid[d]) begin
                check("tdest", m_tdest[d], 4'd1);
                if (prev_stall) begin
                    check("stall_data_stable", m_tdata[d], prev_data);
                    check("stall_last_stable", m_tlast[d], prev_last);
                end
                if (m_tready[d]) begin
                    check("beat_data", m_tdata[d], {24'd0, exp_data[beats]});
                    check("beat_last", m_tlast[d], beats == BURST - 1);
                    beats++;
                    prev_stall = 1'b0;
                end else begin
                    prev_stall = 1'b1;
                    prev_data  = m_tdata[d];
                    prev_last  = m_tlast[d];
                end
            end else begin
                check("valid_dropped_mid_packet", m_tvalid[d], 1'b1);
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("handshake_count", beats, BURST);
        if (mode == 0) check("busy_cycles", busy_cycles, BURST);
        start[d] = hold_start;
        @(negedge clk);
        check("idle_after_last", m_tvalid[d], 1'b0);
        check("busy_after_last", busy[d], 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rx_vec_t     vecs [6];
        logic [15:0] mb, mp;
        logic [31:0] ms;

        vecs[0] = '{1'b1, 32'd5,          1'b0, 16'd1, 16'd0, 32'd5};
        vecs[1] = '{1'b1, 32'd7,          1'b0, 16'd2, 16'd0, 32'd12};
        vecs[2] = '{1'b1, 32'd9,          1'b1, 16'd3, 16'd1, 32'd21};
        vecs[3] = '{1'b0, 32'd100,        1'b1, 16'd3, 16'd1, 32'd21};
        vecs[4] = '{1'b1, 32'hFFFF_FFFF,  1'b0, 16'd4, 16'd1, 32'd20};
        vecs[5] = '{1'b1, 32'd3,          1'b1, 16'd5, 16'd2, 32'd23};

        rst = 1'b1; start = '0; m_tready = '0;
        s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; s_tdest = '0;
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        check("reset_tvalid", m_tvalid[0], 1'b0);
        check("reset_tlast", m_tlast[0], 1'b0);
        check("reset_busy", busy[0], 1'b0);
        check("reset_s_tready", s_tready[0], 1'b0);
        check("reset_rx_beats", rx_beats[0], 16'd0);
        check("reset_rx_pkts", rx_pkts[0], 16'd0);
        check("reset_rx_sum", rx_sum[0], 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("s_tready_after_reset", s_tready[0], 1'b1);

        // Slave tally vectors.
        for (int i = 0; i < 6; i++) begin
            s_tvalid = vecs[i].tvalid;
            s_tdata  = vecs[i].tdata;
            s_tlast  = vecs[i].tlast;
            s_tdest  = 4'(i);
            @(posedge clk); #1;
            check($sformatf("vec%0d_rx_beats", i), rx_beats[0], STATS ? vecs[i].exp_beats : 16'd0);
            check($sformatf("vec%0d_rx_pkts", i), rx_pkts[0], STATS ? vecs[i].exp_pkts : 16'd0);
            check($sformatf("vec%0d_rx_sum", i), rx_sum[0], STATS ? vecs[i].exp_sum : 32'd0);
            check($sformatf("vec%0d_s_tready", i), s_tready[0], 1'b1);
        end

        // Random slave traffic against a running tally.
        mb = vecs[5].exp_beats; mp = vecs[5].exp_pkts; ms = vecs[5].exp_sum;
        for (int i = 0; i < 40; i++) begin
            s_tvalid = 1'($urandom_range(0, 1));
            s_tdata  = $urandom;
            s_tlast  = 1'($urandom_range(0, 1));
            s_tdest  = 4'($urandom_range(0, 15));
            if (s_tvalid) begin
                mb = mb + 16'd1;
                ms = ms + s_tdata;
                if (s_tlast) mp = mp + 16'd1;
            end
            @(posedge clk); #1;
            check("rand_rx_beats", rx_beats[0], STATS ? mb : 16'd0);
            check("rand_rx_pkts", rx_pkts[0], STATS ? mp : 16'd0);
            check("rand_rx_sum", rx_sum[0], STATS ? ms : 32'd0);
        end
        s_tvalid = 1'b0; s_tlast = 1'b0;

        // Packet 1: START held for 3 cycles, one packet only.
        run_pkt(0, 0, 3, 1'b0);
        @(posedge clk); #1;
        // Packet 2: random back-pressure, START kept high past the last beat.
        run_pkt(0, 2, 1, 1'b1);

        // Held START restarts after one idle cycle; then reset after the 2nd beat.
        @(posedge clk); #1;
        start[0] = 1'b0; m_tready[0] = 1'b1;
        @(negedge clk);
        check("restart_valid", m_tvalid[0], 1'b1);
        check("restart_beat1", m_tdata[0], {24'd0, model[0]});
        @(posedge clk); #1;
        model[0] = lfsr_step(model[0]);
        @(negedge clk);
        check("restart_beat2", m_tdata[0], {24'd0, model[0]});
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_tvalid", m_tvalid[0], 1'b0);
        check("midrst_tlast", m_tlast[0], 1'b0);
        check("midrst_busy", busy[0], 1'b0);
        check("midrst_s_tready", s_tready[0], 1'b0);
        check("midrst_rx_beats", rx_beats[0], 16'd0);
        check("midrst_rx_pkts", rx_pkts[0], 16'd0);
        check("midrst_rx_sum", rx_sum[0], 32'd0);
        rst = 1'b0;
        reset_model();
        run_pkt(0, 0, 1, 1'b0);

        // Seed 0x10 with alternating back-pressure, and a zero seed.
        @(posedge clk); #1;
        run_pkt(1, 1, 1, 1'b0);
        @(posedge clk); #1;
        run_pkt(2, 0, 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
